// File: rtl/multiport_register_file_if.sv
// Register-file port bundle: read, write and reservation signals between
// the issue/writeback side (master) and the register file (slave).
interface multiport_register_file_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 8,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*2-1:0]     rd_size;
    logic [NREAD-1:0]       rd_sext;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD*XLEN-1:0]  rd_data_full;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*2-1:0]    wr_size;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic [NREGS-1:0]       busy;

    modport master (
        output rd_addr, rd_size, rd_sext, wr_en, wr_addr, wr_size, wr_data,
               rsv_en, rsv_addr,
        input  rd_data, rd_data_full, busy
    );

    modport slave (
        input  rd_addr, rd_size, rd_sext, wr_en, wr_addr, wr_size, wr_data,
               rsv_en, rsv_addr,
        output rd_data, rd_data_full, busy
    );
endinterface

// File: rtl/multiport_register_file.sv
// Multi-port register file with per-port partial writes, write-first read
// bypass, sized/sign-extended reads and a busy scoreboard for pending writebacks.
module multiport_register_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 8,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input logic clk,
    input logic rst,
    multiport_register_file_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs      [NREGS];
    logic [XLEN-1:0]  next_regs [NREGS];
    logic [XLEN-1:0]  rd_raw    [NREAD];
    logic [NREGS-1:0] next_busy;

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] data,
                                              input logic [1:0]      size);
        case (size)
            2'b00:   merge = {old[XLEN-1:8],  data[7:0]};
            2'b01:   merge = {old[XLEN-1:16], data[15:0]};
            default: merge = data;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0]      size,
                                               input logic            sext);
        case (size)
            2'b00:   extend = {{(XLEN-8){sext & raw[7]}}, raw[7:0]};
            2'b01:   extend = {{(XLEN-16){sext & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Apply write ports in ascending order so higher ports win overlapping lanes.
    always_comb begin
        for (int r = 0; r < NREGS; r++) next_regs[r] = regs[r];
        for (int k = 0; k < NWRITE; k++) begin
            if (bus.wr_en[k]) begin
                next_regs[bus.wr_addr[k*AW +: AW]] =
                    merge(next_regs[bus.wr_addr[k*AW +: AW]],
                          bus.wr_data[k*XLEN +: XLEN],
                          bus.wr_size[k*2 +: 2]);
            end
        end
    end

    // Reads see the post-write value (write-first bypass).
    always_comb begin
        for (int i = 0; i < NREAD; i++) rd_raw[i] = next_regs[bus.rd_addr[i*AW +: AW]];
    end

    // Scoreboard: writes clear, a reservation to the same register overrides.
    always_comb begin
        next_busy = bus.busy;
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (bus.wr_en[k] && bus.wr_addr[k*AW +: AW] == AW'(r)) next_busy[r] = 1'b0;
            end
            if (bus.rsv_en && bus.rsv_addr == AW'(r)) next_busy[r] = 1'b1;
        end
    end

    // Commit storage, registered read outputs and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            bus.rd_data      <= '0;
            bus.rd_data_full <= '0;
            bus.busy         <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs[r] <= next_regs[r];
            for (int i = 0; i < NREAD; i++) begin
                bus.rd_data_full[i*XLEN +: XLEN] <= rd_raw[i];
                bus.rd_data[i*XLEN +: XLEN] <=
                    extend(rd_raw[i], bus.rd_size[i*2 +: 2], bus.rd_sext[i]);
            end
            bus.busy <= next_busy;
        end
    end
endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: default 32-bit/8-reg/2R2W instance plus a 64-bit/16-reg/3R1W instance.
module tb_multiport_register_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // default configuration drive signals
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_size;
    logic [63:0] wr_data;
    logic [5:0]  rd_addr;
    logic [3:0]  rd_size;
    logic [1:0]  rd_sext;
    logic        rsv_en;
    logic [2:0]  rsv_addr;

    // wide configuration drive signals
    logic         w64_en;
    logic [3:0]   w64_addr;
    logic [1:0]   w64_size;
    logic [63:0]  w64_data;
    logic [11:0]  r64_addr;
    logic [5:0]   r64_size;
    logic [2:0]   r64_sext;

    multiport_register_file_if #(.XLEN(32), .NREGS(8), .NREAD(2), .NWRITE(2)) bus ();
    multiport_register_file_if #(.XLEN(64), .NREGS(16), .NREAD(3), .NWRITE(1)) bus64 ();

    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_size  = wr_size;
    assign bus.wr_data  = wr_data;
    assign bus.rd_addr  = rd_addr;
    assign bus.rd_size  = rd_size;
    assign bus.rd_sext  = rd_sext;
    assign bus.rsv_en   = rsv_en;
    assign bus.rsv_addr = rsv_addr;

    assign bus64.wr_en    = w64_en;
    assign bus64.wr_addr  = w64_addr;
    assign bus64.wr_size  = w64_size;
    assign bus64.wr_data  = w64_data;
    assign bus64.rd_addr  = r64_addr;
    assign bus64.rd_size  = r64_size;
    assign bus64.rd_sext  = r64_sext;
    assign bus64.rsv_en   = 1'b0;
    assign bus64.rsv_addr = 4'd0;

    multiport_register_file #(.XLEN(32), .NREGS(8), .NREAD(2), .NWRITE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    multiport_register_file #(.XLEN(64), .NREGS(16), .NREAD(3), .NWRITE(1)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_size = '0; wr_data = '0;
        rd_addr = '0; rd_size = 4'b1010; rd_sext = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        w64_en = 1'b0; w64_addr = '0; w64_size = 2'b10; w64_data = '0;
        r64_addr = '0; r64_size = 6'b101010; r64_sext = '0;
    endtask

    task automatic set_wr(input int p, input logic [2:0] a, input logic [1:0] s, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*3 +: 3] = a;
        wr_size[p*2 +: 2] = s;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic [2:0] a, input logic [1:0] s, input logic x);
        rd_addr[p*3 +: 3] = a;
        rd_size[p*2 +: 2] = s;
        rd_sext[p] = x;
    endtask

    task automatic set_rd64(input int p, input logic [3:0] a, input logic [1:0] s, input logic x);
        r64_addr[p*4 +: 4] = a;
        r64_size[p*2 +: 2] = s;
        r64_sext[p] = x;
    endtask

    initial begin
        idle();
        #12;
        check("reset_rd_data", {32'd0, bus.rd_data}, 64'd0);
        check("reset_busy", {56'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // load r3, reserve r1, read r3 through the bypass
        set_wr(0, 3'd3, 2'b10, 32'hDEADBEEF);
        set_rd(0, 3'd3, 2'b10, 1'b0);
        rsv_en = 1'b1; rsv_addr = 3'd1;
        tick();
        check("load_r3", {32'd0, bus.rd_data_full[31:0]}, 64'hDEADBEEF);
        check("busy_r1", {56'd0, bus.busy}, 64'h02);

        // async reset between edges, with a write pending
        idle();
        set_wr(1, 3'd3, 2'b10, 32'h55555555);
        #2 rst = 1'b1;
        #1;
        check("async_rd_data", {32'd0, bus.rd_data}, 64'd0);
        check("async_rd_full", {32'd0, bus.rd_data_full}, 64'd0);
        check("async_busy", {56'd0, bus.busy}, 64'd0);
        tick();
        tick();
        idle();
        #3 rst = 1'b0;
        set_rd(0, 3'd3, 2'b10, 1'b0);
        tick();
        check("r3_after_reset", {32'd0, bus.rd_data_full[31:0]}, 64'd0);

        // bypass with byte / half reads
        idle();
        set_wr(0, 3'd5, 2'b10, 32'h000080FF);
        set_rd(0, 3'd5, 2'b00, 1'b1);
        set_rd(1, 3'd5, 2'b01, 1'b1);
        tick();
        check("bypass_byte_sext", {32'd0, bus.rd_data[31:0]}, 64'hFFFFFFFF);
        check("bypass_full", {32'd0, bus.rd_data_full[31:0]}, 64'h000080FF);
        check("bypass_half_sext", {32'd0, bus.rd_data[63:32]}, 64'hFFFF80FF);

        // partial merge
        idle();
        set_wr(0, 3'd2, 2'b10, 32'h12345678);
        tick();
        idle();
        set_wr(1, 3'd2, 2'b01, 32'h9999ABCD);
        set_rd(0, 3'd2, 2'b10, 1'b0);
        set_rd(1, 3'd2, 2'b01, 1'b1);
        tick();
        check("half_merge_full", {32'd0, bus.rd_data[31:0]}, 64'h1234ABCD);
        check("half_read_sext", {32'd0, bus.rd_data[63:32]}, 64'hFFFFABCD);
        idle();
        set_rd(1, 3'd2, 2'b01, 1'b0);
        tick();
        check("half_read_zext", {32'd0, bus.rd_data[63:32]}, 64'h0000ABCD);
        idle();
        set_wr(0, 3'd2, 2'b00, 32'hFFFFFF77);
        set_rd(0, 3'd2, 2'b10, 1'b0);
        set_rd(1, 3'd2, 2'b00, 1'b1);
        tick();
        check("byte_merge_full", {32'd0, bus.rd_data[31:0]}, 64'h1234AB77);
        check("byte_read_sext", {32'd0, bus.rd_data[63:32]}, 64'h00000077);

        // write-port priority
        idle();
        set_wr(0, 3'd7, 2'b10, 32'h11223344);
        set_wr(1, 3'd7, 2'b00, 32'h000000AA);
        set_rd(0, 3'd7, 2'b10, 1'b0);
        tick();
        check("prio_full_then_byte", {32'd0, bus.rd_data[31:0]}, 64'h112233AA);
        idle();
        set_wr(0, 3'd7, 2'b00, 32'h000000AA);
        set_wr(1, 3'd7, 2'b10, 32'h11223344);
        set_rd(1, 3'd7, 2'b10, 1'b0);
        tick();
        check("prio_byte_then_full", {32'd0, bus.rd_data[63:32]}, 64'h11223344);
        idle();
        set_rd(0, 3'd7, 2'b10, 1'b0);
        tick();
        check("prio_stored", {32'd0, bus.rd_data[31:0]}, 64'h11223344);

        // scoreboard
        idle();
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        check("rsv_r4", {56'd0, bus.busy}, 64'h10);
        idle();
        set_wr(1, 3'd6, 2'b10, 32'h66666666);
        tick();
        check("busy_hold", {56'd0, bus.busy}, 64'h10);
        idle();
        set_wr(0, 3'd4, 2'b00, 32'h00000001);
        tick();
        check("write_clears_r4", {56'd0, bus.busy}, 64'h00);
        idle();
        rsv_en = 1'b1; rsv_addr = 3'd4;
        set_wr(1, 3'd4, 2'b10, 32'h0BADF00D);
        set_rd(0, 3'd4, 2'b10, 1'b0);
        tick();
        check("rsv_beats_write", {56'd0, bus.busy}, 64'h10);
        check("rsv_write_data", {32'd0, bus.rd_data_full[31:0]}, 64'h0BADF00D);
        idle();
        set_wr(1, 3'd4, 2'b01, 32'h00001234);
        tick();
        check("port1_clears_r4", {56'd0, bus.busy}, 64'h00);

        // wide configuration
        idle();
        w64_en = 1'b1; w64_addr = 4'd9; w64_data = 64'h0123456789ABCDEF;
        tick();
        w64_addr = 4'd15; w64_data = 64'h0000000000000080;
        tick();
        w64_addr = 4'd0; w64_data = 64'hFEDCBA9876548001;
        tick();
        idle();
        set_rd64(0, 4'd9, 2'b10, 1'b0);
        set_rd64(1, 4'd15, 2'b00, 1'b1);
        set_rd64(2, 4'd0, 2'b01, 1'b0);
        tick();
        check("w64_p0_full", bus64.rd_data[63:0], 64'h0123456789ABCDEF);
        check("w64_p1_byte_sext", bus64.rd_data[127:64], 64'hFFFFFFFFFFFFFF80);
        check("w64_p2_half_zext", bus64.rd_data[191:128], 64'h0000000000008001);
        check("w64_p2_raw", bus64.rd_data_full[191:128], 64'hFEDCBA9876548001);
        idle();
        set_rd64(0, 4'd0, 2'b01, 1'b1);
        set_rd64(1, 4'd9, 2'b00, 1'b1);
        set_rd64(2, 4'd15, 2'b10, 1'b0);
        tick();
        check("w64_p0_half_sext", bus64.rd_data[63:0], 64'hFFFFFFFFFFFF8001);
        check("w64_p1_byte_sext_pos", bus64.rd_data[127:64], 64'hFFFFFFFFFFFFFFEF);
        check("w64_p2_full", bus64.rd_data[191:128], 64'h0000000000000080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the PISA core. It generalises the single-write, two-read register file to NREAD read ports and NWRITE write ports, with per-port data size and sign extension. Same-cycle write-to-read bypass and a per-register busy scoreboard let the issue stage detect pending writebacks. It sits between decode/issue (reads, reservations) and the writeback stage (writes).

## Interface
- XLEN, 32, register width in bits; must be ≥ 16 and a multiple of 8.
- NREGS, 8, number of registers; power of two ≥ 2. AW = $clog2(NREGS).
- NREAD, 2, number of read ports, ≥ 1.
- NWRITE, 2, number of write ports, ≥ 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rd_addr  input  NREAD*AW  read address per port; port i is slice [i*AW +: AW].
- rd_size  input  NREAD*2  read size per port: 00 byte, 01 half, 10/11 full word.
- rd_sext  input  NREAD  1 sign-extends a byte/half read, 0 zero-extends.
- rd_data  output  NREAD*XLEN  registered read value after size/extension.
- rd_data_full  output  NREAD*XLEN  registered raw full-width value.
- wr_en  input  NWRITE  write enable per port.
- wr_addr  input  NWRITE*AW  write address per port.
- wr_size  input  NWRITE*2  write size: 00 low byte, 01 low half, 10/11 full.
- wr_data  input  NWRITE*XLEN  write data; only the low bytes are used for partial sizes.
- rsv_en  input  1  reserve: mark rsv_addr busy.
- rsv_addr  input  AW  register to reserve.
- busy  output  NREGS  registered scoreboard, one bit per register.

## Operation
- Storage: NREGS×XLEN registers. All are writable; none is hardwired.
- Partial write merge:
  - byte: new = {old[XLEN-1:8], wr_data[7:0]}.
  - half: new = {old[XLEN-1:16], wr_data[15:0]}.
  - full: new = wr_data.
- Multiple write ports in one cycle: ports apply in ascending index order, each merging onto the result of the lower-indexed ports.
  - Same address, higher index wins on overlapping lanes.
  - Example: port0 full 0x11223344 and port1 byte 0xAA to the same register give 0x112233AA.
- Read path, per port:
  - Raw value = post-write (bypassed) value of rd_addr, i.e. the value the register will hold after this edge.
  - rd_data_full ← raw.
  - rd_data ← raw constrained by rd_size/rd_sext:
    - byte: bits [7:0], upper bits filled with raw[7] if rd_sext else 0.
    - half: bits [15:0], same fill rule using raw[15].
    - full: raw.
- Scoreboard, per register r, next busy[r]:
  - 1 if rsv_en && rsv_addr==r.
  - Else 0 if any wr_en[k] && wr_addr[k]==r (any size clears).
  - Else hold.
  - Reserve beats a simultaneous write to the same register; the write data is still committed.
- busy is advisory only; writes and reads are never blocked by it.

## Timing
- Asynchronous reset: all registers, rd_data, rd_data_full and busy go to 0 immediately and hold while rst=1. The first edge after deassertion performs normal operation.
- Reset asserted mid-cycle discards that cycle's writes and reservations.
- Write latency: a register updates at the edge where wr_en is sampled.
- Read latency: 1 cycle. rd_data at edge N+1 reflects the address presented in cycle N, including writes sampled at edge N+1 (write-first bypass).
- Scoreboard latency: 1 cycle. busy updates at the same edge as the reserve/write.
- All outputs come straight from flops; there is no combinational input-to-output path.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Test plan
- Reset: load r3=0xDEADBEEF, assert rst asynchronously between edges -> all rd_data, rd_data_full and busy read 0 immediately; reading r3 after release returns 0.
- Bypass: in the same cycle, write r5=0x80FF and read r5 as byte with rd_sext=1 -> next cycle rd_data=0xFFFFFFFF, rd_data_full=0x000080FF.
- Partial merge: r2=0x12345678, then half write 0xABCD -> full read 0x1234ABCD; half read with rd_sext=1 -> 0xFFFFABCD, with rd_sext=0 -> 0x0000ABCD.
- Port priority: in one cycle, port0 full 0x11223344 and port1 byte 0xAA to r7 -> r7=0x112233AA; swap the ports -> 0x000000AA merged into 0x11223344 gives 0x11223344 overwritten by port1 full.
- Scoreboard: reserve r4 -> busy[4]=1 next cycle; write r4 -> busy[4]=0; reserve and write r4 in the same cycle -> busy[4]=1 and r4 holds the new data.
- Parameter sweep: XLEN=64, NREGS=16, NREAD=3, NWRITE=1 -> all three ports read independent addresses correctly; byte sign extension fills bits 63:8.
